// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and load/store.
//   One access at a time: IDLE picks a winner and registers its request onto
//   the m_* port, BUSY waits for m_ready (or times out), and RESP pulses the
//   owner's ack for one cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_ack)
//   if_rdata/if_ack               fetch data (held until the next fetch) / done pulse
//   d_req/d_we/d_be/d_addr/d_wdata data request (held until d_ack)
//   d_rdata/d_ack                 load data (held until the next load) / done pulse
//   m_req/m_we/m_be/m_addr/m_wdata registered memory request
//   m_rdata/m_ready               memory read data / access complete this cycle
//   err                           pulses with the ack of an access that timed out
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ready,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);

  typedef struct packed {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } mreq_t;

  logic [1:0]     state;
  logic           owner_d;     // 1: current access belongs to the data port
  logic           err_pend;    // access ended by timeout, report with the ack
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] starve_cnt;
  mreq_t          acc;         // request fields driven onto the memory port
  mreq_t          acc_sel;
  logic           grant_d;

  // Data wins contention until fetch has been passed over STARVE_MAX times.
  always_comb begin
    grant_d = d_req && (!if_req || (starve_cnt != STARVE_TOP));
    acc_sel = '0;
    if (grant_d) begin
      acc_sel.we    = d_we;
      acc_sel.be    = d_be;
      acc_sel.addr  = d_addr;
      acc_sel.wdata = d_wdata;
    end else begin
      acc_sel.we    = 1'b0;
      acc_sel.be    = 4'hF;
      acc_sel.addr  = if_addr;
      acc_sel.wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_d    <= 1'b0;
      err_pend   <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      acc        <= '0;
      m_req      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            acc      <= acc_sel;
            m_req    <= 1'b1;
            owner_d  <= grant_d;
            wait_cnt <= '0;
            err_pend <= 1'b0;
            state    <= S_BUSY;
            if (!grant_d)
              starve_cnt <= '0;
            else if (if_req && (starve_cnt != STARVE_TOP))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= S_RESP;
            // Fetches are always reads; a store leaves d_rdata alone.
            if (!acc.we) begin
              if (owner_d) d_rdata  <= m_rdata;
              else         if_rdata <= m_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            m_req    <= 1'b0;
            err_pend <= 1'b1;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // Requests are not looked at here; the next grant happens in IDLE.
          err_pend <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_we    = acc.we;
  assign m_be    = acc.be;
  assign m_addr  = acc.addr;
  assign m_wdata = acc.wdata;

  assign if_ack = (state == S_RESP) && !owner_d;
  assign d_ack  = (state == S_RESP) &&  owner_d;
  assign err    = (state == S_RESP) &&  err_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [9:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        err;

  mem_port_arbiter #(.AW(10), .STARVE_MAX(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ir;
    logic [9:0]  ia;
    logic        dr, dwe;
    logic [3:0]  dbe;
    logic [9:0]  da;
    logic [31:0] dwd, mrd;
    logic        mrdy;
  } stim_t;

  typedef struct {
    logic        mreq, chk_mf, mwe;
    logic [3:0]  mbe;
    logic [9:0]  maddr;
    logic [31:0] mwd;
    logic        iack, dack, err;
    logic [31:0] ird, drd;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  function automatic stim_t si(logic ir, logic [9:0] ia, logic dr, logic dwe, logic [3:0] dbe,
                               logic [9:0] da, logic [31:0] dwd, logic [31:0] mrd, logic mrdy);
    stim_t s;
    s = '{1'b0, ir, ia, dr, dwe, dbe, da, dwd, mrd, mrdy};
    return s;
  endfunction

  // Expected outputs while an access is on the memory port.
  function automatic exp_t eb(logic mwe, logic [3:0] mbe, logic [9:0] maddr, logic [31:0] mwd,
                              logic [31:0] ird, logic [31:0] drd);
    exp_t e;
    e = '{1'b1, 1'b1, mwe, mbe, maddr, mwd, 1'b0, 1'b0, 1'b0, ird, drd};
    return e;
  endfunction

  // Expected outputs outside BUSY (memory fields not compared).
  function automatic exp_t eo(logic iack, logic dack, logic er, logic [31:0] ird, logic [31:0] drd);
    exp_t e;
    e = '{1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0, iack, dack, er, ird, drd};
    return e;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst = s.rst; if_req = s.ir; if_addr = s.ia;
    d_req = s.dr; d_we = s.dwe; d_be = s.dbe; d_addr = s.da; d_wdata = s.dwd;
    m_rdata = s.mrd; m_ready = s.mrdy;
  endtask

  localparam logic [31:0] F1 = 32'h2008_0005;
  localparam logic [31:0] I1 = 32'hA0A0_0001;
  localparam logic [31:0] I2 = 32'hA0A0_0002;
  localparam logic [31:0] CF = 32'hCAFE_F00D;

  vec_t        tv[$];
  stim_t       s;
  exp_t        e;
  exp_t        e_rst;
  logic [31:0] dk[4];

  initial begin
    dk[0] = 32'h1111_0001; dk[1] = 32'h1111_0002; dk[2] = 32'h1111_0003; dk[3] = 32'h1111_0004;
    e_rst = '{1'b0, 1'b1, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    // Reset
    s = si(0, 0, 0, 0, 0, 0, 0, 0, 0); s.rst = 1'b1;
    tv.push_back('{s, e_rst});

    // Fetch only, immediate ready
    tv.push_back('{si(1, 10'h004, 0, 0, 0, 0, 0, 0, 0), eb(0, 4'hF, 10'h004, 0, 0, 0)});
    tv.push_back('{si(1, 10'h004, 0, 0, 0, 0, 0, F1, 1), eo(1, 0, 0, F1, 0)});
    tv.push_back('{si(1, 10'h004, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, F1, 0)});  // req held in RESP
    tv.push_back('{si(0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, F1, 0)});

    // Store with two wait states
    for (int i = 0; i < 3; i++)
      tv.push_back('{si(0, 0, 1, 1, 4'b0011, 10'h010, 32'hDEAD_BEEF, 0, 0),
                     eb(1, 4'b0011, 10'h010, 32'hDEAD_BEEF, F1, 0)});
    tv.push_back('{si(0, 0, 1, 1, 4'b0011, 10'h010, 32'hDEAD_BEEF, 32'h1234_5678, 1), eo(0, 1, 0, F1, 0)});
    tv.push_back('{si(0, 0, 1, 1, 4'b0011, 10'h010, 32'hDEAD_BEEF, 0, 0), eo(0, 0, 0, F1, 0)});
    tv.push_back('{si(0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, F1, 0)});

    // Contention: D, D, D, then I
    for (int k = 0; k < 3; k++) begin
      tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0),
                     eb(0, 4'h5, 10'h030, 0, F1, (k == 0) ? 32'h0 : dk[k-1])});
      tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, dk[k], 1), eo(0, 1, 0, F1, dk[k])});
      tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0), eo(0, 0, 0, F1, dk[k])});
    end
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0), eb(0, 4'hF, 10'h020, 0, F1, dk[2])});
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, I1, 1), eo(1, 0, 0, I1, dk[2])});
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0), eo(0, 0, 0, I1, dk[2])});
    // Starvation count cleared: data wins again over a fresh fetch
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0), eb(0, 4'h5, 10'h030, 0, I1, dk[2])});
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, dk[3], 1), eo(0, 1, 0, I1, dk[3])});
    tv.push_back('{si(1, 10'h020, 1, 0, 4'h5, 10'h030, 0, 0, 0), eo(0, 0, 0, I1, dk[3])});
    tv.push_back('{si(1, 10'h020, 0, 0, 0, 0, 0, 0, 0), eb(0, 4'hF, 10'h020, 0, I1, dk[3])});
    tv.push_back('{si(1, 10'h020, 0, 0, 0, 0, 0, I2, 1), eo(1, 0, 0, I2, dk[3])});
    tv.push_back('{si(1, 10'h020, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, I2, dk[3])});
    tv.push_back('{si(0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, I2, dk[3])});

    // Timeout: m_req for 15 cycles, then ack + err, rdata untouched
    for (int i = 0; i < 15; i++)
      tv.push_back('{si(0, 0, 1, 0, 4'hF, 10'h040, 0, 32'h55AA_55AA, 0),
                     eb(0, 4'hF, 10'h040, 0, I2, dk[3])});
    tv.push_back('{si(0, 0, 1, 0, 4'hF, 10'h040, 0, 32'h55AA_55AA, 0), eo(0, 1, 1, I2, dk[3])});
    tv.push_back('{si(0, 0, 1, 0, 4'hF, 10'h040, 0, 0, 0), eo(0, 0, 0, I2, dk[3])});
    tv.push_back('{si(0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, I2, dk[3])});

    // Reset while BUSY, then a fresh fetch
    tv.push_back('{si(1, 10'h050, 0, 0, 0, 0, 0, 0, 0), eb(0, 4'hF, 10'h050, 0, I2, dk[3])});
    s = si(1, 10'h050, 0, 0, 0, 0, 0, 0, 0); s.rst = 1'b1;
    tv.push_back('{s, e_rst});
    tv.push_back('{si(1, 10'h050, 0, 0, 0, 0, 0, 0, 0), eb(0, 4'hF, 10'h050, 0, 0, 0)});
    tv.push_back('{si(1, 10'h050, 0, 0, 0, 0, 0, CF, 1), eo(1, 0, 0, CF, 0)});
    tv.push_back('{si(1, 10'h050, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, CF, 0)});
    tv.push_back('{si(0, 0, 0, 0, 0, 0, 0, 0, 0), eo(0, 0, 0, CF, 0)});

    foreach (tv[i]) begin
      apply(tv[i].s);
      @(posedge clk); #1;
      e = tv[i].e;
      chk("m_req", i, 32'(m_req), 32'(e.mreq));
      if (e.chk_mf) begin
        chk("m_we",    i, 32'(m_we),   32'(e.mwe));
        chk("m_be",    i, 32'(m_be),   32'(e.mbe));
        chk("m_addr",  i, 32'(m_addr), 32'(e.maddr));
        chk("m_wdata", i, m_wdata,     e.mwd);
      end
      chk("if_ack",   i, 32'(if_ack), 32'(e.iack));
      chk("d_ack",    i, 32'(d_ack),  32'(e.dack));
      chk("err",      i, 32'(err),    32'(e.err));
      chk("if_rdata", i, if_rdata,    e.ird);
      chk("d_rdata",  i, d_rdata,     e.drd);
    end

    // Hand sequence: bounded wait on a load that never gets m_ready.
    begin
      int  req_cycles;
      bit  acked;
      bit  err_at_ack;
      req_cycles = 0; acked = 0; err_at_ack = 0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 10'h060; d_wdata = '0;
      m_ready = 1'b0; m_rdata = 32'h7777_7777;
      for (int c = 0; c < 40 && !acked; c++) begin
        @(posedge clk); #1;
        if (m_req) req_cycles++;
        if (d_ack) begin acked = 1; err_at_ack = err; end
      end
      chk("to_acked",   1000, 32'(acked),      32'd1);
      chk("to_req_cyc", 1000, 32'(req_cycles), 32'd15);
      chk("to_err",     1000, 32'(err_at_ack), 32'd1);
      chk("to_rdata",   1000, d_rdata,         32'h0);
      @(negedge clk);
      d_req = 1'b0;
      @(posedge clk); #1;
      chk("to_idle_ack", 1001, 32'(d_ack), 32'd0);
      chk("to_idle_err", 1001, 32'(err),   32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
